// File: rtl/mem_access_ctrl_if.sv
// Single-port data-memory bus between the MEM-stage access controller and the memory slave.
// The controller drives the transaction fields; the slave answers with ack and read data.
interface mem_access_ctrl_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ack;
    logic [31:0] rdata;

    modport master (
        output req, we, addr, wdata, be,
        input  ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ack, rdata
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access controller: serializes the pipe a / pipe b requests onto one
// req/ack bus, captures load data per pipe and stalls the pipeline while accesses are in flight.
module mem_access_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     ce_a,
    input  logic                     ce_b,
    input  logic                     we_a,
    input  logic                     we_b,
    input  logic [31:0]              addr_a,
    input  logic [31:0]              addr_b,
    input  logic [31:0]              wdata_a,
    input  logic [31:0]              wdata_b,
    input  logic [3:0]               be_a,
    input  logic [3:0]               be_b,
    mem_access_ctrl_if.master        bus,
    output logic [31:0]              rdata_a,
    output logic [31:0]              rdata_b,
    output logic                     err_a,
    output logic                     err_b,
    output logic                     stall_req
);

    typedef enum logic [1:0] {IDLE, ACC_A, ACC_B, DONE} state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

    state_t      state;
    logic        kill;
    logic [7:0]  wait_cnt;

    logic        lat_we_a;
    logic        lat_we_b;
    logic        lat_ce_b;
    logic [31:0] lat_addr_a;
    logic [31:0] lat_addr_b;
    logic [31:0] lat_wdata_a;
    logic [31:0] lat_wdata_b;
    logic [3:0]  lat_be_a;
    logic [3:0]  lat_be_b;

    logic acc_active;
    logic timed_out;
    logic finish;
    logic killed;

    assign acc_active = (state == ACC_A) || (state == ACC_B);
    assign timed_out  = acc_active && !bus.ack && (wait_cnt == WAIT_LIMIT);
    assign finish     = acc_active && (bus.ack || (wait_cnt == WAIT_LIMIT));
    assign killed     = kill || flush;

    // Bus fields come only from the latched request copies, so there is no input-to-bus path.
    always_comb begin
        bus.req   = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        bus.be    = '0;
        stall_req = 1'b0;
        case (state)
            IDLE: stall_req = ce_a || ce_b;
            ACC_A: begin
                bus.req   = 1'b1;
                bus.we    = lat_we_a;
                bus.addr  = lat_addr_a;
                bus.wdata = lat_wdata_a;
                bus.be    = lat_be_a;
                stall_req = 1'b1;
            end
            ACC_B: begin
                bus.req   = 1'b1;
                bus.we    = lat_we_b;
                bus.addr  = lat_addr_b;
                bus.wdata = lat_wdata_b;
                bus.be    = lat_be_b;
                stall_req = 1'b1;
            end
            default: ;
        endcase
    end

    // A flushed access still runs to ack or timeout, but its result is discarded and the
    // controller returns straight to IDLE without issuing pipe b.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            kill        <= 1'b0;
            wait_cnt    <= '0;
            lat_we_a    <= 1'b0;
            lat_we_b    <= 1'b0;
            lat_ce_b    <= 1'b0;
            lat_addr_a  <= '0;
            lat_addr_b  <= '0;
            lat_wdata_a <= '0;
            lat_wdata_b <= '0;
            lat_be_a    <= '0;
            lat_be_b    <= '0;
            rdata_a     <= '0;
            rdata_b     <= '0;
            err_a       <= 1'b0;
            err_b       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!flush && (ce_a || ce_b)) begin
                        lat_we_a    <= we_a;
                        lat_we_b    <= we_b;
                        lat_ce_b    <= ce_b;
                        lat_addr_a  <= addr_a;
                        lat_addr_b  <= addr_b;
                        lat_wdata_a <= wdata_a;
                        lat_wdata_b <= wdata_b;
                        lat_be_a    <= be_a;
                        lat_be_b    <= be_b;
                        rdata_a     <= '0;
                        rdata_b     <= '0;
                        err_a       <= 1'b0;
                        err_b       <= 1'b0;
                        kill        <= 1'b0;
                        wait_cnt    <= '0;
                        state       <= ce_a ? ACC_A : ACC_B;
                    end
                end
                ACC_A, ACC_B: begin
                    if (finish) begin
                        wait_cnt <= '0;
                        kill     <= 1'b0;
                        if (killed) begin
                            state <= IDLE;
                        end else if (state == ACC_A) begin
                            if (timed_out)
                                err_a <= 1'b1;
                            else if (!lat_we_a)
                                rdata_a <= bus.rdata;
                            state <= lat_ce_b ? ACC_B : DONE;
                        end else begin
                            if (timed_out)
                                err_b <= 1'b1;
                            else if (!lat_we_b)
                                rdata_b <= bus.rdata;
                            state <= DONE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                        if (flush)
                            kill <= 1'b1;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed, table-driven bench for mem_access_ctrl with a hand-played bus slave (TIMEOUT = 8).
// Each table row is one clock cycle: inputs driven after posedge, outputs compared at negedge.
module tb_mem_access_ctrl;

    localparam logic [31:0] G  = 32'hFFFF_FFFC;
    localparam logic [31:0] WB = 32'h5555_AAAA;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        ce_a;
    logic        ce_b;
    logic        we_a;
    logic        we_b;
    logic [31:0] addr_a;
    logic [31:0] addr_b;
    logic [31:0] wdata_a;
    logic [31:0] wdata_b;
    logic [3:0]  be_a;
    logic [3:0]  be_b;
    logic [31:0] rdata_a;
    logic [31:0] rdata_b;
    logic        err_a;
    logic        err_b;
    logic        stall_req;

    mem_access_ctrl_if bus_if ();

    mem_access_ctrl #(.TIMEOUT(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .ce_a      (ce_a),
        .ce_b      (ce_b),
        .we_a      (we_a),
        .we_b      (we_b),
        .addr_a    (addr_a),
        .addr_b    (addr_b),
        .wdata_a   (wdata_a),
        .wdata_b   (wdata_b),
        .be_a      (be_a),
        .be_b      (be_b),
        .bus       (bus_if),
        .rdata_a   (rdata_a),
        .rdata_b   (rdata_b),
        .err_a     (err_a),
        .err_b     (err_b),
        .stall_req (stall_req)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        ce_a;
        logic        ce_b;
        logic        we_a;
        logic        we_b;
        logic [31:0] addr_a;
        logic [31:0] addr_b;
        logic [31:0] wdata_a;
        logic        ack;
        logic [31:0] rdata;
        logic        x_req;
        logic        x_we;
        logic [31:0] x_addr;
        logic [31:0] x_wdata;
        logic [3:0]  x_be;
        logic        x_stall;
        logic [31:0] x_rdata_a;
        logic [31:0] x_rdata_b;
        logic        x_err_a;
        logic        x_err_b;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   passed = 0;

    task automatic add(input logic r, input logic fl, input logic ca, input logic cb,
                       input logic wa, input logic wb, input logic [31:0] aa,
                       input logic [31:0] ab, input logic [31:0] wda, input logic ak,
                       input logic [31:0] rd, input logic xreq, input logic xwe,
                       input logic [31:0] xaddr, input logic [31:0] xwdata,
                       input logic [3:0] xbe, input logic xstall, input logic [31:0] xra,
                       input logic [31:0] xrb, input logic xea, input logic xeb);
        vec_t v;
        v.rst = r;        v.flush = fl;      v.ce_a = ca;       v.ce_b = cb;
        v.we_a = wa;      v.we_b = wb;       v.addr_a = aa;     v.addr_b = ab;
        v.wdata_a = wda;  v.ack = ak;        v.rdata = rd;
        v.x_req = xreq;   v.x_we = xwe;      v.x_addr = xaddr;  v.x_wdata = xwdata;
        v.x_be = xbe;     v.x_stall = xstall;
        v.x_rdata_a = xra; v.x_rdata_b = xrb; v.x_err_a = xea;  v.x_err_b = xeb;
        vecs.push_back(v);
    endtask

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual === expected)
            passed++;
        else
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    endtask

    task automatic apply_stimulus(input vec_t v);
        @(posedge clk);
        #1;
        rst          = v.rst;
        flush        = v.flush;
        ce_a         = v.ce_a;
        ce_b         = v.ce_b;
        we_a         = v.we_a;
        we_b         = v.we_b;
        addr_a       = v.addr_a;
        addr_b       = v.addr_b;
        wdata_a      = v.wdata_a;
        bus_if.ack   = v.ack;
        bus_if.rdata = v.rdata;
    endtask

    task automatic check_row(input int i, input vec_t v);
        check_output($sformatf("row%0d bus_req", i),   {31'd0, bus_if.req}, {31'd0, v.x_req});
        check_output($sformatf("row%0d bus_we", i),    {31'd0, bus_if.we},  {31'd0, v.x_we});
        check_output($sformatf("row%0d bus_addr", i),  bus_if.addr,         v.x_addr);
        check_output($sformatf("row%0d bus_wdata", i), bus_if.wdata,        v.x_wdata);
        check_output($sformatf("row%0d bus_be", i),    {28'd0, bus_if.be},  {28'd0, v.x_be});
        check_output($sformatf("row%0d stall_req", i), {31'd0, stall_req},  {31'd0, v.x_stall});
        check_output($sformatf("row%0d rdata_a", i),   rdata_a,             v.x_rdata_a);
        check_output($sformatf("row%0d rdata_b", i),   rdata_b,             v.x_rdata_b);
        check_output($sformatf("row%0d err_a", i),     {31'd0, err_a},      {31'd0, v.x_err_a});
        check_output($sformatf("row%0d err_b", i),     {31'd0, err_b},      {31'd0, v.x_err_b});
    endtask

    initial begin
        int req_cycles;

        // Load a only, ack in the first bus cycle; rdata_a then holds through DONE and IDLE.
        add(0,0,1,0,0,0,32'h1000,G,32'h0,0,0,          0,0,0,0,0,1,                   0,0,0,0);
        add(0,0,0,0,0,0,G,G,G,1,32'hDEADBEEF,          1,0,32'h1000,0,4'hF,1,         0,0,0,0);
        add(0,0,0,0,0,0,G,G,G,0,0,                     0,0,0,0,0,0,                   32'hDEADBEEF,0,0,0);
        add(0,0,0,0,0,0,G,G,G,0,0,                     0,0,0,0,0,0,                   32'hDEADBEEF,0,0,0);
        // Store a then load b, back-to-back with req held high.
        add(0,0,1,1,1,0,32'h2000,32'h2004,32'h11223344,0,0, 0,0,0,0,0,1,              32'hDEADBEEF,0,0,0);
        add(0,0,0,0,0,0,G,G,G,1,32'h99999999,          1,1,32'h2000,32'h11223344,4'hF,1, 0,0,0,0);
        add(0,0,0,0,0,0,G,G,G,1,32'hCAFEF00D,          1,0,32'h2004,WB,4'h3,1,        0,0,0,0);
        add(0,0,0,0,0,0,G,G,G,0,0,                     0,0,0,0,0,0,                   0,32'hCAFEF00D,0,0);
        // Single load with four wait states.
        add(0,0,1,0,0,0,32'h3000,G,32'h0,0,0,          0,0,0,0,0,1,                   0,32'hCAFEF00D,0,0);
        for (int k = 0; k < 4; k++)
            add(0,0,0,0,0,0,G,G,G,0,0,                 1,0,32'h3000,0,4'hF,1,         0,0,0,0);
        add(0,0,0,0,0,0,G,G,G,1,32'h0BADC0DE,          1,0,32'h3000,0,4'hF,1,         0,0,0,0);
        add(0,0,0,0,0,0,G,G,G,0,0,                     0,0,0,0,0,0,                   32'h0BADC0DE,0,0,0);
        // Pipe a times out after 8 bus cycles, pipe b is then issued normally.
        add(0,0,1,1,0,0,32'h4000,32'h4004,32'h0,0,0,   0,0,0,0,0,1,                   32'h0BADC0DE,0,0,0);
        for (int k = 0; k < 8; k++)
            add(0,0,0,0,0,0,G,G,G,0,0,                 1,0,32'h4000,0,4'hF,1,         0,0,0,0);
        add(0,0,0,0,0,0,G,G,G,1,32'h12345678,          1,0,32'h4004,WB,4'h3,1,        0,0,1,0);
        add(0,0,0,0,0,0,G,G,G,0,0,                     0,0,0,0,0,0,                   0,32'h12345678,1,0);
        // Flush during ACC_A, ack after three waits; pipe b must never appear.
        add(0,0,1,1,0,0,32'h5000,32'h5004,32'h0,0,0,   0,0,0,0,0,1,                   0,32'h12345678,1,0);
        add(0,1,0,0,0,0,G,G,G,0,0,                     1,0,32'h5000,0,4'hF,1,         0,0,0,0);
        add(0,0,0,0,0,0,G,G,G,0,0,                     1,0,32'h5000,0,4'hF,1,         0,0,0,0);
        add(0,0,0,0,0,0,G,G,G,0,0,                     1,0,32'h5000,0,4'hF,1,         0,0,0,0);
        add(0,0,0,0,0,0,G,G,G,1,32'hAAAA5555,          1,0,32'h5000,0,4'hF,1,         0,0,0,0);
        add(0,0,0,0,0,0,G,G,G,0,0,                     0,0,0,0,0,0,                   0,0,0,0);
        add(0,0,0,0,0,0,G,G,G,0,0,                     0,0,0,0,0,0,                   0,0,0,0);
        // Reset asserted in ACC_B, then a stray ack while idle.
        add(0,0,1,1,0,0,32'h6000,32'h6004,32'hA5A5A5A5,0,0, 0,0,0,0,0,1,              0,0,0,0);
        add(0,0,0,0,0,0,G,G,G,1,32'h13579BDF,          1,0,32'h6000,32'hA5A5A5A5,4'hF,1, 0,0,0,0);
        add(1,0,0,0,0,0,G,G,G,0,0,                     1,0,32'h6004,WB,4'h3,1,        32'h13579BDF,0,0,0);
        add(0,0,0,0,0,0,G,G,G,0,0,                     0,0,0,0,0,0,                   0,0,0,0);
        add(0,0,0,0,0,0,G,G,G,1,32'hFFFFFFFF,          0,0,0,0,0,0,                   0,0,0,0);
        add(0,0,0,0,0,0,G,G,G,0,0,                     0,0,0,0,0,0,                   0,0,0,0);
        // Flush in IDLE suppresses the access start.
        add(0,1,1,0,0,0,32'h7000,G,32'h0,0,0,          0,0,0,0,0,1,                   0,0,0,0);
        add(0,0,0,0,0,0,G,G,G,0,0,                     0,0,0,0,0,0,                   0,0,0,0);

        rst          = 1'b1;
        flush        = 1'b0;
        ce_a         = 1'b0;
        ce_b         = 1'b0;
        we_a         = 1'b0;
        we_b         = 1'b0;
        addr_a       = '0;
        addr_b       = '0;
        wdata_a      = '0;
        wdata_b      = WB;
        be_a         = 4'hF;
        be_b         = 4'h3;
        bus_if.ack   = 1'b0;
        bus_if.rdata = '0;

        $display("[TB] reset state");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_output("reset bus_req",   {31'd0, bus_if.req}, 32'd0);
        check_output("reset bus_we",    {31'd0, bus_if.we},  32'd0);
        check_output("reset bus_addr",  bus_if.addr,         32'd0);
        check_output("reset bus_wdata", bus_if.wdata,        32'd0);
        check_output("reset bus_be",    {28'd0, bus_if.be},  32'd0);
        check_output("reset stall_req", {31'd0, stall_req},  32'd0);
        check_output("reset rdata_a",   rdata_a,             32'd0);
        check_output("reset rdata_b",   rdata_b,             32'd0);
        check_output("reset err_a",     {31'd0, err_a},      32'd0);
        check_output("reset err_b",     {31'd0, err_b},      32'd0);

        $display("[TB] applying %0d table rows", vecs.size());
        for (int i = 0; i < vecs.size(); i++) begin
            apply_stimulus(vecs[i]);
            @(negedge clk);
            check_row(i, vecs[i]);
        end

        $display("[TB] standalone timeout on pipe a");
        @(posedge clk);
        #1;
        ce_a       = 1'b1;
        we_a       = 1'b0;
        addr_a     = 32'h8000;
        bus_if.ack = 1'b0;
        @(posedge clk);
        #1;
        ce_a   = 1'b0;
        addr_a = G;
        req_cycles = 0;
        @(negedge clk);
        while (bus_if.req === 1'b1 && req_cycles < 40) begin
            req_cycles++;
            @(negedge clk);
        end
        check_output("timeout req_cycles", req_cycles,          32'd8);
        check_output("timeout err_a",      {31'd0, err_a},      32'd1);
        check_output("timeout rdata_a",    rdata_a,             32'd0);
        check_output("timeout stall_req",  {31'd0, stall_req},  32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

MEM-stage data-memory access controller for the dual-issue pipeline. It consumes the memory requests that the EX/MEM register delivers for pipes a and b. It serializes them onto a single-port data bus with a req/ack handshake and returns load data per pipe. While accesses are outstanding it raises a MEM-stage stall request.

## Interface
- TIMEOUT, 255: max cycles to wait for bus_ack per access; 8-bit counter, 1..255.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  pipeline flush (exception/eret), same cycle as EX/MEM flush.
- ce_a, ce_b  in  1  memory request valid, pipe a / b.
- we_a, we_b  in  1  1 = store, 0 = load.
- addr_a, addr_b  in  32  byte address, word-aligned by EX.
- wdata_a, wdata_b  in  32  store data, already lane-shifted.
- be_a, be_b  in  4  byte enables.
- bus_req  out  1  transaction valid.
- bus_we  out  1  write.
- bus_addr  out  32  address.
- bus_wdata  out  32  write data.
- bus_be  out  4  byte enables.
- bus_ack  in  1  slave completes current transaction this cycle.
- bus_rdata  in  32  read data, valid with bus_ack.
- rdata_a, rdata_b  out  32  captured load word per pipe.
- err_a, err_b  out  1  access timed out; rdata for that pipe is zero.
- stall_req  out  1  hold pipeline (drives stall_mem).

## Operation
- FSM states: IDLE, ACC_A, ACC_B, DONE.
- Request fields (we, addr, wdata, be, ce_b) of both pipes are latched into internal registers on the IDLE exit edge. Bus outputs are driven only from these latched copies.
- IDLE:
  - stall_req = ce_a | ce_b.
  - ce_a → ACC_A; else ce_b → ACC_B; else stay.
  - On leaving, clear rdata_a/b and err_a/b to 0.
- ACC_A:
  - bus_req = 1, fields from latched pipe a; stall_req = 1.
  - On bus_ack: rdata_a ← bus_rdata if load; stores leave rdata_a at 0.
  - Then → ACC_B if latched ce_b, else → DONE.
- ACC_B: same, with pipe b fields and rdata_b; on ack → DONE.
- DONE: bus_req = 0, stall_req = 0; → IDLE unconditionally. The pipeline advances at the end of this cycle. rdata/err stay valid through DONE and hold until the next IDLE exit.
- Timeout:
  - An 8-bit wait counter clears on entry to ACC_A/ACC_B and increments each cycle without ack.
  - If the counter reaches TIMEOUT-1 without ack, set err for that pipe, leave rdata = 0, drop bus_req next cycle, and transition as if acked.
- Flush:
  - In IDLE or DONE: → IDLE; no access is started that cycle.
  - In ACC_A/ACC_B: set kill flag. An in-flight transaction is never abandoned; bus_req stays until ack or timeout. The state then → IDLE instead of ACC_B/DONE, and pipe b is not issued.
  - stall_req stays 1 while killed. rdata/err are not updated by a killed access.
- bus_req may stay high across ACC_A→ACC_B; each ack completes exactly one transaction. bus_ack while bus_req = 0 is ignored.

## Timing
- Reset values:
  - State IDLE; bus_req, bus_we, stall_req = 0.
  - bus_addr, bus_wdata, bus_be, rdata_a/b, err_a/b, kill, counter = 0.
- Reset mid-transaction drops bus_req the following cycle. The bus slave is reset by the same rst.
- stall_req and bus_* are combinational from state and latched registers; no input→bus_* combinational path.
- Single access, ack in first bus cycle:
  - c0 IDLE: stall = 1.
  - c1 ACC_A: bus_req = 1, ack.
  - c2 DONE: stall = 0.
  - Total 2 stall cycles; each extra wait cycle adds 1.
- Dual access, zero-wait: IDLE, ACC_A, ACC_B, DONE → 3 stall cycles.
- Timeout access occupies exactly TIMEOUT bus cycles.

## Test plan
- Load a only: addr_a = 0x1000, slave acks c1 with 0xDEADBEEF → bus_req high only in c1 with addr 0x1000, we = 0; stall_req = 1 in c0–c1, 0 in c2; rdata_a = 0xDEADBEEF in c2.
- Store a + load b: a store 0x2000/0x11223344/be = 0xF, b load 0x2004; ack on each first cycle → two back-to-back bus cycles in order a then b, bus_req continuous; rdata_b = slave data; 3 stall cycles.
- Wait states: slave delays ack 4 cycles on a single load → bus fields stable throughout, stall_req = 1 for 6 cycles.
- Timeout, TIMEOUT = 8, slave never acks pipe a; pipe b also requested → bus_req on a for 8 cycles; err_a = 1, rdata_a = 0; then b is issued normally.
- Flush during ACC_A with ack delayed 3 cycles, ce_b = 1 → bus_req held until ack; pipe b never issued; FSM returns to IDLE; rdata_a unchanged (0).
- rst asserted in ACC_B → next cycle bus_req = 0, stall_req = 0, all outputs 0, state IDLE.
